// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with sign fix-up and ready/valid on both sides.
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN-1:0]     r_b, r_result;
  logic [2:0]          r_f3;
  logic                r_neg;
  logic [TAG_W-1:0]    r_tag, r_tag_out;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Request decode: signedness, magnitudes and the special cases that bypass CALC
  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_is_div;
  logic            w_div0, w_ovf, w_special, w_accept, w_neg;
  logic [XLEN-1:0] w_a_abs, w_b_abs, w_special_res;

  assign w_is_div   = funct3[2];
  assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_a_neg    = w_a_signed & op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & op_b[XLEN-1];
  assign w_a_abs    = neg_if(op_a, w_a_neg);
  assign w_b_abs    = neg_if(op_b, w_b_neg);
  assign w_neg      = (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div0     = w_is_div && (op_b == '0);
  assign w_ovf      = w_is_div && !funct3[0] && (op_b == '1) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}});
  assign w_special  = w_div0 | w_ovf;
  assign w_special_res = w_div0 ? (funct3[1] ? op_a : '1)
                                : (funct3[1] ? '0 : op_a);
  assign w_accept   = (r_state == IDLE) && in_valid && !flush;

  // One iteration: multiplier/quotient occupies the low half, partial product/remainder the high half
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod_neg;
  logic [XLEN-1:0]   w_fix;

  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + ({(XLEN+1){r_prod[0]}} & {1'b0, r_b});
  assign w_mul_next  = {w_mul_sum, r_prod[XLEN-1:1]};
  assign w_div_shift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_next  = w_div_diff[XLEN] ? {w_div_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                                        : {w_div_diff[XLEN-1:0],  r_prod[XLEN-2:0], 1'b1};
  assign w_prod_neg  = r_neg ? -r_prod : r_prod;

  always_comb begin
    w_fix = r_prod[XLEN-1:0];
    case (r_f3)
      3'b001, 3'b010, 3'b011: w_fix = w_prod_neg[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix = neg_if(r_prod[XLEN-1:0], r_neg);
      3'b110, 3'b111:         w_fix = neg_if(r_prod[2*XLEN-1:XLEN], r_neg);
      default:                w_fix = r_prod[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next = w_special ? DONE : CALC;
      end
      CALC: begin
        if (flush)              w_next = IDLE;
        else if (r_cnt == '0)   w_next = FIX;
      end
      FIX:  w_next = flush ? IDLE : DONE;
      DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_prod    <= '0;
      r_b       <= '0;
      r_f3      <= '0;
      r_neg     <= 1'b0;
      r_tag     <= '0;
      r_result  <= '0;
      r_tag_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_f3   <= funct3;
          r_tag  <= tag_in;
          r_neg  <= w_neg;
          r_prod <= {{XLEN{1'b0}}, w_a_abs};
          r_b    <= w_b_abs;
          r_cnt  <= CW'(XLEN-1);
          if (w_special) begin
            r_result  <= w_special_res;
            r_tag_out <= tag_in;
          end
        end
        CALC: begin
          r_prod <= r_f3[2] ? w_div_next : w_mul_next;
          r_cnt  <= r_cnt - CW'(1);
        end
        // Result/tag only move on the edge that actually enters DONE
        FIX: if (!flush) begin
          r_result  <= w_fix;
          r_tag_out <= r_tag;
        end
        default: ;
      endcase
    end
  end

  assign result  = r_result;
  assign tag_out = r_tag_out;

endmodule

// File: doc/riscv_muldiv_unit.md
# riscv_muldiv_unit

Iterative, parametrised RV32M/RV64M multiply/divide unit for the RISC-V datapath. It sits beside the ALU and is fed the same two register-file operands plus funct3. It returns a result and destination-register tag after a multi-cycle computation. Ready/valid handshakes on both input and output let a multi-cycle or pipelined control unit stall on it. It adds signed and high-half multiply, divide and remainder, none of which the single-cycle ALU provides.

## Interface
- XLEN, 32: operand/result width; must be 32 or 64.
- TAG_W, 5: width of the pass-through destination tag (rd index).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- funct3  in  3  RISC-V M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- tag_in  in  TAG_W  destination tag captured with the request.
- flush  in  1  abandon the in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  computed value.
- tag_out  out  TAG_W  tag of the request that produced result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid, capture funct3/tag and go to CALC. For signed operands (MULH, MULHSU op_a; MULH, DIV, REM both), store absolute values and record the result sign.
  - Special cases skip CALC and go straight to DONE with the final result:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return op_a.
  - Signed overflow (op_a = most-negative, op_b = -1): DIV returns op_a; REM returns 0.
- CALC: one iteration per cycle for exactly XLEN cycles; count register runs XLEN-1 down to 0.
  - Multiply: shift-add into a 2·XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX: apply sign correction (two's-complement negate when the recorded sign is negative).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Select the low half (MUL) or high half (MULH*) of the product, or the quotient/remainder.
  - Load result and go to DONE.
- DONE: out_valid=1; result/tag_out held stable. When out_valid && out_ready, go to IDLE.
- Arithmetic is modulo 2^XLEN; the product register is 2·XLEN wide; no exceptions are raised.
- flush: in CALC, FIX or DONE, next state is IDLE and out_valid drops the following cycle; no result is delivered. In IDLE, flush has priority over in_valid: the request is not accepted.
- reset: at any state, next state is IDLE and all datapath registers clear. Reset has priority over flush and all handshakes.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, tag_out=0.
- Accept edge = rising edge with in_valid && in_ready, called cycle 0.
- Normal latency: out_valid first high in cycle XLEN+2 (34 for XLEN=32).
- Special-case latency: out_valid high in cycle 1.
- Back-to-back: a new request can be accepted in the cycle after the result handshake. in_ready is low throughout CALC, FIX and DONE.
- result and tag_out change only on the edge entering DONE; they hold while out_ready=0.

## Test plan
- XLEN=32, MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB, out_valid in cycle 34, tag_out = tag_in.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIV/DIVU by 0 with op_a=0x1234 → 0xFFFFFFFF, REM → 0x1234; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. All special cases: out_valid in cycle 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result/tag stable, in_ready=0. Raise out_ready → IDLE next cycle, and a new request is accepted that cycle.
- flush at cycle 10 of CALC, and reset at cycle 20 of a second op → no out_valid pulse; in_ready=1 the next cycle; a following MUL 3×5 → 15 with full latency.
